// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU pipeline control blocks.
package cpu_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam int X0_IDX = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_MISS   = 2'd2,
        ST_REFILL = 2'd3
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: arbitrates cache-miss, load-use and branch controls,
// sequences the miss wait and keeps stall/flush counters plus a miss watchdog.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = cpu_ctrl_pkg::REG_AW,
    parameter int CNT_W        = 32,
    parameter int MISS_TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_uses_rs2_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              id_branch_taken_i,
    input  logic              dcache_req_i,
    input  logic              dcache_hit_i,
    input  logic              dcache_ack_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              mem_stall_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic              err_o
);
    import cpu_ctrl_pkg::*;

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] RUN    = ST_RUN;
    localparam logic [1:0] MISS   = ST_MISS;
    localparam logic [1:0] REFILL = ST_REFILL;

    localparam int MW = $clog2(MISS_TIMEOUT + 1);
    localparam logic [MW-1:0] TO_M1 = MW'(MISS_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          miss, hazard;
    logic [MW-1:0] miss_cnt;

    assign miss   = dcache_req_i & ~dcache_hit_i;
    assign hazard = ex_memread_i & (ex_rd_i != REG_AW'(X0_IDX)) &
                    ((ex_rd_i == id_rs1_i) | (id_uses_rs2_i & (ex_rd_i == id_rs2_i)));

    always_comb begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        mem_stall_o    = 1'b0;
        state_d        = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (miss) begin
                    mem_stall_o = 1'b1;
                    state_d     = MISS;
                end else begin
                    // A branch under a load-use hazard re-resolves next cycle since IF/ID is held.
                    if (hazard) begin
                        id_ex_bubble_o = 1'b1;
                    end else begin
                        pc_write_o    = 1'b1;
                        if_id_write_o = 1'b1;
                        if_id_flush_o = id_branch_taken_i;
                    end
                    if (!start_i) state_d = IDLE;
                end
            end
            MISS: begin
                mem_stall_o = 1'b1;
                if (dcache_ack_i) state_d = REFILL;
            end
            REFILL: begin
                mem_stall_o = 1'b1;
                state_d     = start_i ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // err_o rises after the MISS_TIMEOUT-th consecutive MISS cycle; the FSM keeps waiting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                    err_o <= 1'b0;
        else if ((state_q == MISS) && (miss_cnt >= TO_M1)) err_o <= 1'b1;
    end

    sat_counter #(.W(MW)) u_miss_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (state_q == MISS),
        .clear ((state_q == RUN) & miss),
        .q     (miss_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (mem_stall_o | id_ex_bubble_o),
        .clear (1'b0),
        .q     (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (if_id_flush_o),
        .clear (1'b0),
        .q     (flush_cnt_o)
    );

    assign state_o = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: two instances (wide/default and narrow/short-timeout) against a rule-level model.
module tb_pipe_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
    logic       id_uses_rs2_i = 1'b0, ex_memread_i = 1'b0, id_branch_taken_i = 1'b0;
    logic       dcache_req_i = 1'b0, dcache_hit_i = 1'b0, dcache_ack_i = 1'b0;

    logic        b_pcw, b_ifw, b_fl, b_bub, b_ms, b_err;
    logic [1:0]  b_st;
    logic [31:0] b_sc, b_fc;
    logic        s_pcw, s_ifw, s_fl, s_bub, s_ms, s_err;
    logic [1:0]  s_st;
    logic [2:0]  s_sc, s_fc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .MISS_TIMEOUT(1024)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .id_branch_taken_i(id_branch_taken_i),
        .dcache_req_i(dcache_req_i), .dcache_hit_i(dcache_hit_i), .dcache_ack_i(dcache_ack_i),
        .pc_write_o(b_pcw), .if_id_write_o(b_ifw), .if_id_flush_o(b_fl),
        .id_ex_bubble_o(b_bub), .mem_stall_o(b_ms), .state_o(b_st),
        .stall_cnt_o(b_sc), .flush_cnt_o(b_fc), .err_o(b_err));

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(3), .MISS_TIMEOUT(4)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .id_branch_taken_i(id_branch_taken_i),
        .dcache_req_i(dcache_req_i), .dcache_hit_i(dcache_hit_i), .dcache_ack_i(dcache_ack_i),
        .pc_write_o(s_pcw), .if_id_write_o(s_ifw), .if_id_flush_o(s_fl),
        .id_ex_bubble_o(s_bub), .mem_stall_o(s_ms), .state_o(s_st),
        .stall_cnt_o(s_sc), .flush_cnt_o(s_fc), .err_o(s_err));

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (rule level) ----------------
    // mode: 0 idle, 1 running, 2 waiting for refill, 3 refill data cycle
    bit     m_valid = 0;
    int     m_mode;
    longint m_sb, m_fb, m_ss, m_fs;
    int     m_misscyc;
    bit     m_errb, m_errs;

    // returns {pc_write, if_id_write, flush, bubble, mem_stall}
    function automatic logic [4:0] exp_ctl(input int mode);
        bit lu;
        lu = ex_memread_i && (ex_rd_i != 0) &&
             ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
        if (mode == 0) return 5'b00000;
        if (mode >= 2) return 5'b00001;
        if (dcache_req_i && !dcache_hit_i) return 5'b00001;
        if (lu) return 5'b00010;
        if (id_branch_taken_i) return 5'b11100;
        return 5'b11000;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        logic [4:0] c;
        int nxt;
        if (rst_i) begin
            m_valid = 1; m_mode = 0; m_sb = 0; m_fb = 0; m_ss = 0; m_fs = 0;
            m_misscyc = 0; m_errb = 0; m_errs = 0;
        end else if (m_valid) begin
            c = exp_ctl(m_mode);
            if (c[0] || c[1]) begin
                if (m_sb < 64'hFFFF_FFFF) m_sb++;
                if (m_ss < 7) m_ss++;
            end
            if (c[2]) begin
                if (m_fb < 64'hFFFF_FFFF) m_fb++;
                if (m_fs < 7) m_fs++;
            end
            nxt = m_mode;
            case (m_mode)
                0: if (start_i) nxt = 1;
                1: if (dcache_req_i && !dcache_hit_i) begin nxt = 2; m_misscyc = 0; end
                   else if (!start_i) nxt = 0;
                2: begin
                    m_misscyc++;
                    if (m_misscyc >= 4)    m_errs = 1;
                    if (m_misscyc >= 1024) m_errb = 1;
                    if (dcache_ack_i) nxt = 3;
                end
                default: nxt = start_i ? 1 : 0;
            endcase
            m_mode = nxt;
        end
    end

    always @(negedge clk_i) begin
        logic [4:0] c;
        if (m_valid) begin
            c = exp_ctl(m_mode);
            chk("pc_write",     b_pcw, c[4]); chk("if_id_write", b_ifw, c[3]);
            chk("if_id_flush",  b_fl,  c[2]); chk("bubble",      b_bub, c[1]);
            chk("mem_stall",    b_ms,  c[0]); chk("state",       b_st,  m_mode);
            chk("stall_cnt",    b_sc,  m_sb); chk("flush_cnt",   b_fc,  m_fb);
            chk("err",          b_err, m_errb);
            chk("s_pc_write",   s_pcw, c[4]); chk("s_bubble",    s_bub, c[1]);
            chk("s_flush",      s_fl,  c[2]); chk("s_mem_stall", s_ms,  c[0]);
            chk("s_state",      s_st,  m_mode);
            chk("s_stall_cnt",  s_sc,  m_ss); chk("s_flush_cnt", s_fc,  m_fs);
            chk("s_err",        s_err, m_errs);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        bit req, hit, memread;
        logic [4:0] rd, rs1, rs2;
        bit uses2, br;
        bit e_pcw, e_ifw, e_fl, e_bub;
    } vec_t;

    vec_t vt[10];

    task automatic cyc();
        @(posedge clk_i); #1;
    endtask

    task automatic clr_in();
        ex_memread_i = 0; ex_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_uses_rs2_i = 0;
        id_branch_taken_i = 0; dcache_req_i = 0; dcache_hit_i = 0; dcache_ack_i = 0;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #3 rst_i = 1; #1;
        chk("rst_state", b_st, 0); chk("rst_mem_stall", b_ms, 0);
        chk("rst_err_s", s_err, 0); chk("rst_stall_cnt", b_sc, 0);
        #10 rst_i = 0;
        cyc();
    endtask

    initial begin
        longint s0;
        vt[0] = '{0,0, 0, 7, 7, 7, 1, 0, 1,1,0,0};
        vt[1] = '{0,0, 1, 7, 7, 2, 0, 0, 0,0,0,1};
        vt[2] = '{0,0, 1, 7, 1, 7, 0, 0, 1,1,0,0};
        vt[3] = '{0,0, 1, 7, 1, 7, 1, 0, 0,0,0,1};
        vt[4] = '{0,0, 1, 0, 0, 0, 1, 0, 1,1,0,0};
        vt[5] = '{0,0, 1, 0, 0, 0, 1, 1, 1,1,1,0};
        vt[6] = '{0,0, 0, 9, 9, 9, 1, 1, 1,1,1,0};
        vt[7] = '{0,0, 1,31,31, 0, 0, 1, 0,0,0,1};
        vt[8] = '{0,0, 1,12,13,14, 1, 0, 1,1,0,0};
        vt[9] = '{1,1, 0, 3, 3, 3, 1, 0, 1,1,0,0};

        #7 rst_i = 1;
        #16 rst_i = 0;
        cyc();

        // reset / start
        for (int i = 0; i < 3; i++) begin
            chk("idle_state", b_st, 0); chk("idle_pc_write", b_pcw, 0); chk("idle_ifw", b_ifw, 0);
            cyc();
        end
        start_i = 1; #1;
        chk("idle_start_pcw", b_pcw, 0);
        cyc();
        chk("run_state", b_st, 1); chk("run_pc_write", b_pcw, 1);

        // load-use on rs2
        ex_memread_i = 1; ex_rd_i = 5; id_rs2_i = 5; id_uses_rs2_i = 1; id_rs1_i = 3; #1;
        chk("lu_pcw", b_pcw, 0); chk("lu_ifw", b_ifw, 0); chk("lu_bubble", b_bub, 1);
        chk("lu_stall0", b_sc, 0);
        cyc();
        chk("lu_stall1", b_sc, 1);
        ex_rd_i = 0; id_rs2_i = 0; #1;
        chk("x0_bubble", b_bub, 0); chk("x0_pcw", b_pcw, 1);
        cyc();

        // branch vs load-use
        ex_rd_i = 5; id_rs2_i = 5; id_branch_taken_i = 1; #1;
        chk("brlu_bubble", b_bub, 1); chk("brlu_flush", b_fl, 0);
        cyc();
        ex_memread_i = 0; #1;
        chk("br_flush", b_fl, 1);
        cyc();
        chk("br_flush_cnt", b_fc, 1);
        clr_in();

        // table-driven RUN vectors
        foreach (vt[i]) begin
            dcache_req_i = vt[i].req; dcache_hit_i = vt[i].hit; ex_memread_i = vt[i].memread;
            ex_rd_i = vt[i].rd; id_rs1_i = vt[i].rs1; id_rs2_i = vt[i].rs2;
            id_uses_rs2_i = vt[i].uses2; id_branch_taken_i = vt[i].br; #1;
            chk($sformatf("vec%0d_pcw", i), b_pcw, vt[i].e_pcw);
            chk($sformatf("vec%0d_ifw", i), b_ifw, vt[i].e_ifw);
            chk($sformatf("vec%0d_flush", i), b_fl, vt[i].e_fl);
            chk($sformatf("vec%0d_bubble", i), b_bub, vt[i].e_bub);
            chk($sformatf("vec%0d_stall", i), b_ms, 0);
            cyc();
        end
        clr_in();

        // cache miss with ack on the 10th MISS cycle
        s0 = b_sc;
        dcache_req_i = 1; dcache_hit_i = 0; #1;
        chk("miss_stall", b_ms, 1); chk("miss_pcw", b_pcw, 0);
        cyc();
        dcache_req_i = 0;
        for (int i = 0; i < 10; i++) begin
            start_i = (i == 4) ? 1'b0 : 1'b1;
            dcache_ack_i = (i == 9);
            #1;
            chk("miss_wait_state", b_st, 2); chk("miss_wait_stall", b_ms, 1);
            cyc();
        end
        dcache_ack_i = 0; start_i = 1; #1;
        chk("refill_state", b_st, 3); chk("refill_stall", b_ms, 1);
        cyc();
        chk("post_refill_state", b_st, 1); chk("post_refill_stall", b_ms, 0);
        chk("miss_stall_cnt", b_sc - s0, 12); chk("miss_err_b", b_err, 0);
        chk("miss_err_s", s_err, 1);

        // watchdog on the short-timeout instance
        do_reset();
        cyc();
        dcache_req_i = 1; #1;
        cyc();
        dcache_req_i = 0;
        for (int k = 1; k <= 4; k++) begin
            chk("wd_err_pre", s_err, 0);
            cyc();
        end
        chk("wd_err_set", s_err, 1);
        for (int k = 0; k < 3; k++) cyc();
        chk("wd_err_held", s_err, 1); chk("wd_still_miss", s_st, 2);
        dcache_ack_i = 1; cyc(); dcache_ack_i = 0;
        chk("wd_refill", s_st, 3); chk("wd_err_refill", s_err, 1);
        cyc();
        chk("wd_run", s_st, 1); chk("wd_err_run", s_err, 1);

        // reset in the middle of a miss
        dcache_req_i = 1; cyc(); dcache_req_i = 0;
        chk("mid_miss_state", b_st, 2);
        #3 rst_i = 1; #1;
        chk("rstmiss_state", b_st, 0); chk("rstmiss_stall", b_ms, 0); chk("rstmiss_err", s_err, 0);
        #10 rst_i = 0;
        cyc();

        // saturation: 10 bubbles
        cyc();
        ex_memread_i = 1; ex_rd_i = 4; id_rs1_i = 4;
        for (int k = 0; k < 10; k++) cyc();
        chk("sat_small", s_sc, 7); chk("sat_big", b_sc, 10);
        clr_in();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            start_i           = ($urandom_range(0, 99) < 95);
            dcache_req_i      = ($urandom_range(0, 99) < 25);
            dcache_hit_i      = ($urandom_range(0, 99) < 75);
            dcache_ack_i      = ($urandom_range(0, 99) < 12);
            ex_memread_i      = $urandom_range(0, 1);
            ex_rd_i           = 5'($urandom_range(0, 3));
            id_rs1_i          = 5'($urandom_range(0, 3));
            id_rs2_i          = 5'($urandom_range(0, 3));
            id_uses_rs2_i     = $urandom_range(0, 1);
            id_branch_taken_i = ($urandom_range(0, 99) < 25);
            cyc();
        end
        clr_in();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
